// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - switch synchroniser and per-bit debouncer with rise/fall/change strobes
// A shared tick paces every bit's stability counter; sw follows s2 after STABLE_TICKS ticks of disagreement.
module sw_debounce #(
  parameter int WIDTH        = 16,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             CLK100MHZ,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             change
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] sw_q, sw_d, rise_q, rise_d, fall_q, fall_d;
  logic             change_q, change_d;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  // Agreement always clears progress, so a bit only updates after an unbroken mismatch run.
  always_comb begin
    sw_d   = sw_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == sw_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
          sw_d[i]   = s2_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    change_d = |(rise_d | fall_d);
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      tick_cnt_q <= '0;
      sw_q       <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      change_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q       <= sw_raw;
      s2_q       <= s1_q;
      tick_cnt_q <= tick_cnt_d;
      sw_q       <= sw_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      change_q   <= change_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw     = sw_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign change = change_q;

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-conditioning stage between the Basys3 slide switches and the `top` design logic. It synchronises the asynchronous `sw_raw` pins into `CLK100MHZ` and debounces each bit independently with a shared millisecond tick. It presents a clean `sw` bus to downstream logic, plus one-cycle rise/fall strobes and an any-change strobe, so consumers never see metastable or bouncing switch values.

## Interface
- `WIDTH`, 16, number of switch bits.
- `TICK_DIV`, 100000, clock cycles per debounce tick (1 ms at 100 MHz); legal range ≥1.
- `STABLE_TICKS`, 10, consecutive ticks a bit must differ from `sw` before `sw` follows; legal range ≥1.

Ports:
- `CLK100MHZ` in 1: sole clock, 100 MHz.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `sw_raw` in WIDTH: raw switch pins, asynchronous to the clock.
- `sw` out WIDTH: debounced switch state.
- `rise` out WIDTH: 1-cycle pulse per bit when the `sw` bit goes 0→1.
- `fall` out WIDTH: 1-cycle pulse per bit when the `sw` bit goes 1→0.
- `change` out 1: 1-cycle pulse when any `sw` bit changes.

## Operation
- **Reset** (`rst_n`=0, asynchronous) clears the following to 0:
  - both synchroniser stages, the tick counter and all per-bit counters;
  - `sw`, `rise`, `fall` and `change`.
- **Synchroniser:** 2-FF chain per bit: `s1<=sw_raw`, `s2<=s1`. Only `s2` is used downstream.
- **Tick generator:**
  - `tick_cnt` counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` is combinational and high while `tick_cnt==TICK_DIV-1`.
  - With TICK_DIV=1, `tick` is high every cycle.
- **Per-bit debounce counter** `cnt[i]` is ceil(log2(STABLE_TICKS+1)) bits wide. Priority on each edge:
  1. `s2[i]==sw[i]`: `cnt[i]<=0`. This happens regardless of tick; any return to agreement cancels progress.
  2. Mismatch, `tick`=1, `cnt[i]==STABLE_TICKS-1`: `sw[i]<=s2[i]`, `cnt[i]<=0`, `rise[i]<=s2[i]`, `fall[i]<=~s2[i]`.
  3. Mismatch, `tick`=1, otherwise: `cnt[i]<=cnt[i]+1`.
  4. Mismatch, `tick`=0: `cnt[i]` holds.
- **Strobes:**
  - `rise` and `fall` are registered. They default to 0 every cycle except on the update edge of case 2.
  - `change` is `|(next rise | next fall)`, registered on the same edge as the strobes.
- **Simultaneous bit changes:**
  - Bits are independent. Several bits may update on the same edge, giving multiple `rise`/`fall` bits and a single `change` pulse.
  - `rise[i]` and `fall[i]` are never both high.
- **Power-up with switches on:** after reset release, `sw` starts at 0. It follows the high switches through the normal debounce and produces `rise` pulses; this is intended.
- **Reset mid-debounce:** all progress is discarded. `sw` returns to 0 immediately and asynchronously, and no strobe is emitted.

## Timing
- The synchroniser adds 2 cycles. A `sw_raw` change captured at edge k appears on `s2` after edge k+1.
- **First tick:** at the (TICK_DIV)-th rising edge after reset release, counting the first edge as 1; `tick_cnt` is TICK_DIV-1 during that cycle.
- **Debounce latency** from `s2` mismatch onset to `sw` update is between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles, depending on tick phase.
- `sw`, `rise`, `fall` and `change` update on the same edge. Strobes are high for exactly one cycle.
- **Glitch rejection:**
  - A mismatch shorter than one tick period never reaches a count of STABLE_TICKS.
  - Any agreement cycle resets `cnt[i]`.
- Throughput: a bit may toggle again STABLE_TICKS ticks after its previous update.

## Test plan
All scenarios use TICK_DIV=4, STABLE_TICKS=3 and release `rst_n` at t=0. Ticks occur at edges 4, 8, 12, …

- **Reset values:** hold `rst_n`=0 with `sw_raw`=16'hFFFF.
  - Required: `sw`=0, `rise`=`fall`=0, `change`=0 throughout.
  - Asserting `rst_n` low while `sw`=16'hFFFF clears `sw` to 0 without waiting for a clock edge.
- **Clean rise:** `sw_raw`=16'h0001 stable from reset release.
  - Required: `sw`=16'h0001 after edge 12.
  - `rise`=16'h0001 and `change`=1 for exactly that one cycle; `fall`=0.
- **Bounce rejection:**
  - Stimulus: with `sw`=0, toggle `sw_raw[3]` every 3 cycles for 40 cycles, then hold it at 1.
  - Required: no `sw[3]` change or strobe during bouncing; `sw[3]`=1 within 12 cycles (+2 sync) of the final settle.
- **Simultaneous multi-bit:** from `sw`=16'hA5A5 (settled), drive `sw_raw`=16'h5A5A.
  - Required: a single update edge with `sw`=16'h5A5A, `rise`=16'h5A5A, `fall`=16'hA5A5, one `change` pulse.
- **Reset mid-debounce:** `sw_raw`=16'hFFFF; pulse `rst_n` low for 1 cycle after edge 9.
  - Required: `sw` stays 0 and no strobe appears before 12 cycles after release.
  - `sw`=16'hFFFF appears at edge 12 after release.
- **Glitch shorter than tick:** with `sw`=0, drive `sw_raw[0]`=1 for 2 cycles, repeated every 8 cycles so the glitch never spans 3 ticks.
  - Required: `sw[0]` stays 0 indefinitely and no strobes appear.
